// File: rtl/vm_defs.sv
// rtl/vm_defs.sv - shared definitions for the binary-to-BCD conversion scheduler
package vm_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int BIN_W       = 7;
  localparam int BCD_W       = 8;
  localparam int BCD9_W      = 9;
  localparam logic [2:0] ITER_LAST = 3'd6;
  localparam int NCH_DEFAULT = 4;

  // One double-dabble iteration: correct both digits, then shift in the operand MSB.
  function automatic logic [BCD9_W-1:0] dabble_shift(input logic [BCD_W-1:0] v, input logic b);
    logic [BCD_W-1:0] a;
    a = v;
    if (a[3:0] >= 4'd5) a[3:0] = a[3:0] + 4'd3;
    if (a[7:4] >= 4'd5) a[7:4] = a[7:4] + 4'd3;
    return {a, b};
  endfunction

endpackage

// File: rtl/dabble_engine.sv
// rtl/dabble_engine.sv - sequential shift-add-3 binary-to-BCD engine, one bit per step
module dabble_engine
  import vm_defs::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [BIN_W-1:0]  operand,
  input  logic              step,
  output logic [BCD9_W-1:0] bcd9,
  output logic              last_iter
);

  logic [BIN_W-1:0] opnd_q;
  logic [2:0]       iter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opnd_q <= '0;
      bcd9   <= '0;
      iter_q <= '0;
    end else if (load) begin
      opnd_q <= operand;
      bcd9   <= '0;
      iter_q <= '0;
    end else if (step) begin
      bcd9   <= dabble_shift(bcd9[BCD_W-1:0], opnd_q[BIN_W-1]);
      opnd_q <= {opnd_q[BIN_W-2:0], 1'b0};
      iter_q <= iter_q + 3'd1;
    end
  end

  assign last_iter = (iter_q == ITER_LAST);

endmodule

// File: rtl/bcd_convert_scheduler.sv
// rtl/bcd_convert_scheduler.sv - round-robin sharing of one BCD engine across NCH requesters
// BCD_SATURATE_EN: when defined, values 100..127 write 8'h99 instead of the value-100 digits.
module bcd_convert_scheduler
  import vm_defs::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_i,
  input  logic [BIN_W*NCH-1:0] value_i,
  output logic [NCH-1:0]       ack_o,
  output logic [BCD_W*NCH-1:0] bcd_o,
  output logic [NCH-1:0]       ovf_o,
  output logic                 busy_o
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_grant_q, chan_q, grant_idx;
  logic [BIN_W-1:0]  sel_value;
  logic              eng_load, eng_step, last_iter;
  logic [BCD9_W-1:0] bcd9;
  logic [BCD_W-1:0]  result;
  logic              result_ovf;
  int                cand;

  // Scan from farthest to nearest offset so the channel right after last_grant wins.
  always_comb begin
    grant_idx = last_grant_q;
    cand      = 0;
    for (int i = NCH; i >= 1; i--) begin
      cand = (int'(last_grant_q) + i) % NCH;
      if (req_i[cand]) grant_idx = IW'(cand);
    end
  end

  assign sel_value = value_i[grant_idx*BIN_W +: BIN_W];

  dabble_engine u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (eng_load),
    .operand   (sel_value),
    .step      (eng_step),
    .bcd9      (bcd9),
    .last_iter (last_iter)
  );

`ifdef BCD_SATURATE_EN
  assign result = bcd9[BCD9_W-1] ? 8'h99 : bcd9[BCD_W-1:0];
`else
  assign result = bcd9[BCD_W-1:0];
`endif
  assign result_ovf = bcd9[BCD9_W-1];

  always_comb begin
    state_d  = state_q;
    eng_load = 1'b0;
    eng_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          eng_load = 1'b1;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        eng_step = 1'b1;
        if (last_iter) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(NCH - 1);
      chan_q       <= '0;
      ack_o        <= '0;
      busy_o       <= 1'b0;
      bcd_o        <= '0;
      ovf_o        <= '0;
    end else begin
      state_q <= state_d;
      busy_o  <= (state_d != ST_IDLE);
      ack_o   <= '0;
      if (eng_load) chan_q <= grant_idx;
      if (state_q == ST_SHIFT && state_d == ST_DONE) ack_o[chan_q] <= 1'b1;
      // The result lands at the end of DONE, so it is visible the cycle after ack_o.
      if (state_q == ST_DONE) begin
        bcd_o[chan_q*BCD_W +: BCD_W] <= result;
        ovf_o[chan_q]                <= result_ovf;
        last_grant_q                 <= chan_q;
      end
    end
  end

endmodule

// File: doc/bcd_convert_scheduler.md
# bcd_convert_scheduler

Shares one sequential binary-to-BCD engine among NCH requesters (price, inserted amount, change, stock count) in the vending-machine display path. Each requester raises a request with a 7-bit binary value. A round-robin arbiter grants one request at a time and the engine converts it over 7 shift cycles. The 2-digit packed BCD result is held in a per-channel output register that feeds the 7-segment scan logic.

## Interface
- NCH, 4, number of requester channels (2..8)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NCH  per-channel conversion request, level; held until matching ack_o
- value_i  in  7*NCH  binary operand; channel k at [7k+6:7k]; must be stable while req_i[k] is high and not yet granted
- ack_o  out  NCH  one-cycle pulse when channel k's result is written
- bcd_o  out  8*NCH  channel k result at [8k+7:8k], {tens, ones}
- ovf_o  out  NCH  per-channel flag: last converted value was ≥ 100
- busy_o  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**
  - If any req_i bit is high, grant the first requesting channel after last_grant, wrapping modulo NCH.
  - Latch that channel's value_i and channel index.
  - Clear the engine and its 3-bit iteration counter, then go to SHIFT.
  - With no request, stay in IDLE.
- **SHIFT**
  - Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift the operand MSB into the BCD vector.
  - The BCD vector is 9 bits: hundreds bit, tens, ones.
  - After 7 iterations (counter 0..6), go to DONE.
- **DONE**
  - Write bcd_o and ovf_o for the latched channel.
  - Pulse ack_o for that channel and update last_grant to it.
  - Return to IDLE.
- **Arithmetic:** value 0..99 gives tens/ones directly with ovf = 0. For 100..127, the hundreds bit is set: ovf = 1 and the written result is defined under Configuration.
- **Request withdrawal:**
  - Dropped before grant: the request is never serviced.
  - Dropped after grant: the conversion completes, the result is written, and ack_o still pulses.
- **Operand changes:** value_i changes after grant are ignored.
- **Re-request:** a channel may reassert req_i the cycle after its ack_o. Under contention it is served only after all other requesting channels.
- **Fairness:** no channel waits more than NCH−1 conversions once requesting.
- **Register retention:** bcd_o/ovf_o of non-granted channels hold their values.
- **Reset:** rst_n low at any time, including mid-SHIFT, forces immediately:
  - state IDLE, engine and counter cleared
  - ack_o = 0, busy_o = 0, bcd_o all 0, ovf_o all 0
  - last_grant = NCH−1, so channel 0 has first priority
  - no partial result is written

## Timing
- Cycle 0: IDLE samples req_i and grants.
- Cycles 1–7: SHIFT.
- Cycle 8: DONE. ack_o is high, and bcd_o is updated at the clock edge ending cycle 8.
- Cycle 9: IDLE, may grant again.
- Request-seen to ack is 8 cycles; sustained throughput is one conversion per 9 cycles.
- ack_o and bcd_o/ovf_o are registered outputs; the new bcd_o is visible the cycle after the ack_o pulse.
- busy_o is registered, high from cycle 1 through cycle 8.

## Configuration
- BCD_SATURATE_EN defined: values 100..127 write bcd = 8'h99, ovf = 1.
- BCD_SATURATE_EN undefined: values 100..127 write bcd = {tens, ones} of (value − 100), e.g. 115 → 8'h15, with ovf = 1.
- Values 0..99 behave identically in both builds.

## Structure
- Shared package/header `vm_defs`:
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE
  - BIN_W = 7, BCD_W = 8, ITER_LAST = 3'd6
  - default NCH
- Sub-module `dabble_engine`:
  - holds the operand shift register, 9-bit BCD vector and iteration counter
  - inputs: clk, rst_n, load, operand, step
  - outputs: bcd9, last_iter
- The top level holds the FSM, the round-robin arbiter, and the per-channel result registers.

## Test plan
- Reset: assert rst_n = 0 with random inputs → bcd_o = 0, ovf_o = 0, ack_o = 0, busy_o = 0. Release, then req_i = 4'b0001 with value 7'd42 → ack_o[0] at cycle 8, bcd_o[7:0] = 8'h42, ovf_o[0] = 0.
- Boundary values on channel 1:
  - 0 → 8'h00
  - 9 → 8'h09
  - 10 → 8'h10
  - 99 → 8'h99, ovf = 0
- Overflow on channel 2, value 127:
  - without BCD_SATURATE_EN → 8'h27, ovf = 1
  - with BCD_SATURATE_EN → 8'h99, ovf = 1
- Contention: all four requests asserted simultaneously with values 11, 22, 33, 44 and held until their acks → acks in order ch0, ch1, ch2, ch3, 9 cycles apart, results 8'h11/8'h22/8'h33/8'h44. Then keep ch0 and ch2 requesting → order continues ch0, ch2, ch0.
- Withdrawal/stability: ch3 request granted with 56, value_i changed to 78 at cycle 3 and req dropped at cycle 4 → ack_o[3] at cycle 8, result 8'h56.
- Reset mid-SHIFT: pulse rst_n low at cycle 4 of a ch1 conversion → no ack_o, bcd_o[15:8] = 0, FSM in IDLE. Next request (ch1) is served first because last_grant = NCH−1.
